// File: rtl/apb_decoder_pkg.sv
// Purpose : shared types and constants for the APB address decoder.
// Latency : n/a (types, constants and a width helper only).
// Backpr. : n/a.
// Contents: FSM state enum, fault-cause encodings, default 3-slave base/mask
//           map (slave 0 in the low-order 32 bits), index-width helper.
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam logic FAULT_UNMAPPED = 1'b0;
  localparam logic FAULT_TIMEOUT  = 1'b1;

  // Slave 0 = system block, 1 = UART, 2 = SRAM (upper half of the map).
  localparam logic [95:0] DEF_SLV_BASE = {32'h8000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [95:0] DEF_SLV_MASK = {32'h8000_0000, 32'hFE00_0000, 32'hFFFF_0000};

  // Width of a slave index; a single-slave map still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_decoder_if.sv
// Purpose : APB bus bundle between the core master, the decoder and the slaves.
// Latency : n/a (wires only).
// Backpr. : n/a.
// Modports: master = the outside world (core master + slave peripherals),
//           slave  = the decoder itself.
interface apb_decoder_if #(
  parameter int NUM_SLAVES = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]            paddr;
  logic                             psel;
  logic                             penable;
  logic [DATA_WIDTH-1:0]            prdata;
  logic                             pready;
  logic                             perr;
  logic [NUM_SLAVES-1:0]            s_psel;
  logic [NUM_SLAVES-1:0]            s_penable;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_prdata;
  logic [NUM_SLAVES-1:0]            s_pready;
  logic [NUM_SLAVES-1:0]            s_perr;

  modport master (
    output paddr, psel, penable, s_prdata, s_pready, s_perr,
    input  prdata, pready, perr, s_psel, s_penable
  );

  modport slave (
    input  paddr, psel, penable, s_prdata, s_pready, s_perr,
    output prdata, pready, perr, s_psel, s_penable
  );
endinterface

// File: rtl/apb_decoder_addr_match.sv
// Purpose : base/mask comparators plus lowest-index priority encoder.
// Latency : combinational.
// Backpr. : none.
// Ports   : paddr_i address in; hit_idx_o winning slave index; miss_o no slave hit.
module apb_addr_match
  import apb_pkg::*;
#(
  parameter int                             NUM_SLAVES = 3,
  parameter int                             ADDR_WIDTH = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_BASE = DEF_SLV_BASE,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_MASK = DEF_SLV_MASK,
  parameter int                             IDX_W      = idx_width(NUM_SLAVES)
) (
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  output logic [IDX_W-1:0]      hit_idx_o,
  output logic                  miss_o
);

  // Scan from the top index down so the lowest matching index is the last write.
  always_comb begin
    hit_idx_o = '0;
    miss_o    = 1'b1;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((paddr_i & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit_idx_o = IDX_W'(i);
        miss_o    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/apb_decoder.sv
// Purpose : APB decoder / response mux with watchdog and sticky fault capture.
// Latency : zero added; slave pready/prdata/perr pass through combinationally.
// Backpr. : master waits on the selected slave; misses and timeouts force completion.
// Ports   : pclk/presetn (async active-low); bus (apb_decoder_if.slave) carries the
//           master and slave APB signals; fault_valid/fault_addr/fault_cause are the
//           sticky capture, fault_clr clears it.
// Config  : APB_DECODER_TIMEOUT_EN enables the watchdog counter and timeout path.
module apb_decoder
  import apb_pkg::*;
#(
  parameter int                             NUM_SLAVES     = 3,
  parameter int                             ADDR_WIDTH     = 32,
  parameter int                             DATA_WIDTH     = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_BASE       = DEF_SLV_BASE,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_MASK       = DEF_SLV_MASK,
  parameter int                             TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  presetn,
  apb_decoder_if.slave          bus,
  output logic                  fault_valid,
  output logic [ADDR_WIDTH-1:0] fault_addr,
  output logic                  fault_cause,
  input  logic                  fault_clr
);

  localparam int IDX_W = idx_width(NUM_SLAVES);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("apb_decoder: TIMEOUT_CYCLES must be at least 2");
  end

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        sel_q, sel_d, hit_idx;
  logic                    miss_q, miss_d, miss;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    fault_valid_q, fault_valid_d;
  logic [ADDR_WIDTH-1:0]   fault_addr_q, fault_addr_d;
  logic                    slv_rdy, slv_err, setup, timeout, fault_evt, capture;
  logic [DATA_WIDTH-1:0]   slv_dat, prdata_int;
  logic [NUM_SLAVES-1:0]   psel_int, pen_int;
  logic                    pready_int, perr_int;

  apb_addr_match #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .SLV_BASE   (SLV_BASE),
    .SLV_MASK   (SLV_MASK),
    .IDX_W      (IDX_W)
  ) u_match (
    .paddr_i   (bus.paddr),
    .hit_idx_o (hit_idx),
    .miss_o    (miss)
  );

  assign setup   = bus.psel & ~bus.penable;
  assign slv_rdy = bus.s_pready[sel_q];
  assign slv_err = bus.s_perr[sel_q];
  assign slv_dat = bus.s_prdata[sel_q*DATA_WIDTH +: DATA_WIDTH];

`ifdef APB_DECODER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_cause_q, fault_cause_d;

  // cnt holds (ACCESS cycle number - 1); it cannot pass TIMEOUT_CYCLES-1
  // because that value forces completion, so no saturation is needed.
  assign timeout = (state_q == ACCESS) && !miss_q && !slv_rdy &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d         = cnt_q;
    fault_cause_d = fault_cause_q;
    if (state_q == IDLE) begin
      if (setup) cnt_d = '0;
    end else if (!pready_int) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (capture) fault_cause_d = miss_q ? FAULT_UNMAPPED : FAULT_TIMEOUT;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt_q         <= '0;
      fault_cause_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      fault_cause_q <= fault_cause_d;
    end
  end

  assign fault_cause = fault_cause_q;
`else
  assign timeout     = 1'b0;
  assign fault_cause = FAULT_UNMAPPED;
`endif

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    miss_d     = miss_q;
    addr_d     = addr_q;
    psel_int   = '0;
    pen_int    = '0;
    pready_int = 1'b0;
    perr_int   = 1'b0;
    prdata_int = '0;
    fault_evt  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.psel && !miss) psel_int[hit_idx] = 1'b1;
        if (setup) begin
          sel_d   = hit_idx;
          miss_d  = miss;
          addr_d  = bus.paddr;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (miss_q) begin
          pready_int = 1'b1;
          perr_int   = 1'b1;
          fault_evt  = 1'b1;
          state_d    = IDLE;
        end else if (slv_rdy) begin
          psel_int[sel_q] = 1'b1;
          pen_int[sel_q]  = bus.penable;
          pready_int      = 1'b1;
          perr_int        = slv_err;
          prdata_int      = slv_dat;
          state_d         = IDLE;
        end else if (timeout) begin
          // Slave select/enable deliberately left low: the transfer is abandoned.
          pready_int = 1'b1;
          perr_int   = 1'b1;
          fault_evt  = 1'b1;
          state_d    = IDLE;
        end else begin
          psel_int[sel_q] = 1'b1;
          pen_int[sel_q]  = bus.penable;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A new fault wins over a simultaneous clear.
  assign capture = fault_evt && (!fault_valid_q || fault_clr);

  always_comb begin
    fault_valid_d = fault_valid_q;
    fault_addr_d  = fault_addr_q;
    if (capture) begin
      fault_valid_d = 1'b1;
      fault_addr_d  = addr_q;
    end else if (fault_clr) begin
      fault_valid_d = 1'b0;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q       <= IDLE;
      sel_q         <= '0;
      miss_q        <= 1'b0;
      addr_q        <= '0;
      fault_valid_q <= 1'b0;
      fault_addr_q  <= '0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      miss_q        <= miss_d;
      addr_q        <= addr_d;
      fault_valid_q <= fault_valid_d;
      fault_addr_q  <= fault_addr_d;
    end
  end

  // In IDLE the selects follow psel combinationally, so gate them with reset
  // to keep slaves deselected while presetn is low.
  assign bus.s_psel    = psel_int & {NUM_SLAVES{presetn}};
  assign bus.s_penable = pen_int & {NUM_SLAVES{presetn}};
  assign bus.pready    = pready_int;
  assign bus.perr      = perr_int;
  assign bus.prdata    = prdata_int;
  assign fault_valid   = fault_valid_q;
  assign fault_addr    = fault_addr_q;

endmodule

// File: tb/tb_apb_decoder.sv
// Purpose : self-checking bench for apb_decoder with a transaction-level model.
// Latency : n/a.
// Backpr. : n/a.
module tb_apb_decoder;

  localparam int TO = 16;
`ifdef APB_DECODER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam logic [31:0] BASE_T [3] = '{32'h0000_0000, 32'h1000_0000, 32'h8000_0000};
  localparam logic [31:0] MASK_T [3] = '{32'hFFFF_0000, 32'hFE00_0000, 32'h8000_0000};

  logic        pclk;
  logic        presetn;
  logic        fault_valid;
  logic [31:0] fault_addr;
  logic        fault_cause;
  logic        fault_clr;

  int n_checks = 0;
  int n_errors = 0;

  apb_decoder_if #(.NUM_SLAVES(3), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb_decoder #(
    .NUM_SLAVES     (3),
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .pclk        (pclk),
    .presetn     (presetn),
    .bus         (bus.slave),
    .fault_valid (fault_valid),
    .fault_addr  (fault_addr),
    .fault_cause (fault_cause),
    .fault_clr   (fault_clr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Address map as a lookup: first matching entry, -1 when none.
  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < 3; i++)
      if ((a & MASK_T[i]) == BASE_T[i]) return i;
    return -1;
  endfunction

  // ---------------- transaction-level model + per-cycle compare ----------------
  bit          m_busy  = 1'b0;
  int          m_cyc   = 0;
  int          m_tgt   = 0;
  logic [31:0] m_addr  = '0;
  bit          f_valid = 1'b0;
  logic [31:0] f_addr  = '0;
  bit          f_cause = 1'b0;

  always @(negedge pclk) begin
    logic [2:0]  e_sel, e_en;
    logic        e_rdy, e_err;
    logic [31:0] e_dat;
    bit          evt, evt_cause;
    e_sel = '0; e_en = '0; e_rdy = 1'b0; e_err = 1'b0; e_dat = '0;
    evt = 1'b0; evt_cause = 1'b0;
    if (presetn) begin
      if (!m_busy) begin
        if (bus.psel && decode(bus.paddr) >= 0) e_sel = 3'b001 << decode(bus.paddr);
      end else if (m_tgt < 0) begin
        e_rdy = 1'b1; e_err = 1'b1; evt = 1'b1; evt_cause = 1'b0;
      end else if (bus.s_pready[m_tgt]) begin
        e_sel = 3'b001 << m_tgt;
        e_en  = bus.penable ? e_sel : 3'b000;
        e_rdy = 1'b1;
        e_err = bus.s_perr[m_tgt];
        e_dat = bus.s_prdata[m_tgt*32 +: 32];
      end else if (TO_EN && m_cyc == TO) begin
        e_rdy = 1'b1; e_err = 1'b1; evt = 1'b1; evt_cause = 1'b1;
      end else begin
        e_sel = 3'b001 << m_tgt;
        e_en  = bus.penable ? e_sel : 3'b000;
      end
    end else begin
      f_valid = 1'b0; f_addr = '0; f_cause = 1'b0;
    end
    check("mdl_s_psel",      64'(bus.s_psel),    64'(e_sel));
    check("mdl_s_penable",   64'(bus.s_penable), 64'(e_en));
    check("mdl_pready",      64'(bus.pready),    64'(e_rdy));
    check("mdl_perr",        64'(bus.perr),      64'(e_err));
    check("mdl_prdata",      64'(bus.prdata),    64'(e_dat));
    check("mdl_fault_valid", 64'(fault_valid),   64'(f_valid));
    check("mdl_fault_addr",  64'(fault_addr),    64'(f_addr));
    check("mdl_fault_cause", 64'(fault_cause),   64'(f_cause));
    if (!presetn) begin
      m_busy = 1'b0; m_cyc = 0;
    end else begin
      if (evt && (!f_valid || fault_clr)) begin
        f_valid = 1'b1; f_addr = m_addr; f_cause = evt_cause;
      end else if (fault_clr) begin
        f_valid = 1'b0;
      end
      if (!m_busy) begin
        if (bus.psel && !bus.penable) begin
          m_busy = 1'b1; m_cyc = 1; m_tgt = decode(bus.paddr); m_addr = bus.paddr;
        end
      end else if (e_rdy) begin
        m_busy = 1'b0;
      end else begin
        m_cyc++;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic miss_xfer(input logic [31:0] a);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = a;
    tick();
    bus.penable = 1'b1;
    tick();
    bus.psel = 1'b0; bus.penable = 1'b0;
  endtask

  initial begin
    presetn = 1'b0; fault_clr = 1'b0;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = 32'h8000_0010;
    bus.s_prdata = '0; bus.s_pready = '0; bus.s_perr = '0;

    // Reset state, with psel already high.
    repeat (2) tick();
    #1;
    check("rst_s_psel",      64'(bus.s_psel),  64'(0));
    check("rst_pready",      64'(bus.pready),  64'(0));
    check("rst_fault_valid", 64'(fault_valid), 64'(0));
    bus.psel = 1'b0;
    tick();
    presetn = 1'b1;
    tick();

    // penable without a preceding setup is ignored.
    bus.psel = 1'b1; bus.penable = 1'b1; bus.paddr = 32'h8000_0000;
    bus.s_pready = 3'b100; bus.s_prdata[64 +: 32] = 32'h0000_0099;
    #1 check("nosetup_pready0", 64'(bus.pready), 64'(0));
    tick();
    #1 check("nosetup_pready1", 64'(bus.pready), 64'(0));
    bus.psel = 1'b0; bus.penable = 1'b0; bus.s_pready = '0;
    tick();

    // SRAM read at 0x80000010, two wait cycles.
    bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = 32'h8000_0010;
    #1 check("sram_setup_psel", 64'(bus.s_psel), 64'(3'b100));
    tick();
    bus.penable = 1'b1;
    #1 check("sram_a1_penable", 64'(bus.s_penable), 64'(3'b100));
    check("sram_a1_pready", 64'(bus.pready), 64'(0));
    tick();
    #1 check("sram_a2_pready", 64'(bus.pready), 64'(0));
    tick();
    bus.s_pready = 3'b100; bus.s_prdata[64 +: 32] = 32'hDEAD_BEEF;
    #1 check("sram_a3_pready", 64'(bus.pready), 64'(1));
    check("sram_a3_prdata", 64'(bus.prdata), 64'(32'hDEAD_BEEF));
    check("sram_a3_perr",   64'(bus.perr),   64'(0));
    tick();
    bus.psel = 1'b0; bus.penable = 1'b0; bus.s_pready = '0;
    tick();

    // Unmapped access at 0x20000000.
    bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = 32'h2000_0000;
    #1 check("miss_setup_psel", 64'(bus.s_psel), 64'(0));
    tick();
    bus.penable = 1'b1;
    #1 check("miss_pready", 64'(bus.pready), 64'(1));
    check("miss_perr",   64'(bus.perr),   64'(1));
    check("miss_prdata", 64'(bus.prdata), 64'(0));
    check("miss_s_psel", 64'(bus.s_psel), 64'(0));
    tick();
    bus.psel = 1'b0; bus.penable = 1'b0;
    #1 check("miss_fv",    64'(fault_valid), 64'(1));
    check("miss_faddr", 64'(fault_addr),  64'(32'h2000_0000));
    check("miss_fcause", 64'(fault_cause), 64'(0));
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    #1 check("clr_fv", 64'(fault_valid), 64'(0));

    // UART at 0x10000004 that never answers.
    bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = 32'h1000_0004;
    #1 check("uart_setup_psel", 64'(bus.s_psel), 64'(3'b010));
    tick();
    bus.penable = 1'b1;
`ifdef APB_DECODER_TIMEOUT_EN
    for (int k = 1; k <= TO; k++) begin
      #1;
      if (k < TO) begin
        check("to_wait_pready", 64'(bus.pready), 64'(0));
        check("to_wait_s_psel", 64'(bus.s_psel), 64'(3'b010));
      end else begin
        check("to_pready",    64'(bus.pready),    64'(1));
        check("to_perr",      64'(bus.perr),      64'(1));
        check("to_s_psel",    64'(bus.s_psel),    64'(0));
        check("to_s_penable", 64'(bus.s_penable), 64'(0));
      end
      tick();
    end
    bus.psel = 1'b0; bus.penable = 1'b0;
    #1 check("to_fv",     64'(fault_valid), 64'(1));
    check("to_fcause", 64'(fault_cause), 64'(1));
    check("to_faddr",  64'(fault_addr),  64'(32'h1000_0004));
    miss_xfer(32'h3000_0000);
    #1 check("sticky_faddr",  64'(fault_addr),  64'(32'h1000_0004));
    check("sticky_fcause", 64'(fault_cause), 64'(1));
`else
    repeat (20) begin
      #1 check("nto_wait_pready", 64'(bus.pready), 64'(0));
      tick();
    end
    bus.s_pready = 3'b010; bus.s_prdata[32 +: 32] = 32'h0000_1234;
    #1 check("nto_pready", 64'(bus.pready), 64'(1));
    check("nto_prdata", 64'(bus.prdata), 64'(32'h0000_1234));
    tick();
    bus.psel = 1'b0; bus.penable = 1'b0; bus.s_pready = '0;
    #1 check("nto_fv", 64'(fault_valid), 64'(0));
    miss_xfer(32'h3000_0000);
    #1 check("nto_miss_faddr", 64'(fault_addr), 64'(32'h3000_0000));
    miss_xfer(32'h5000_0000);
    #1 check("sticky_faddr",  64'(fault_addr),  64'(32'h3000_0000));
    check("sticky_fcause", 64'(fault_cause), 64'(0));
`endif

    // fault_clr coincides with a new unmapped completion at 0x40000000.
    bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = 32'h4000_0000;
    tick();
    bus.penable = 1'b1; fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0; bus.psel = 1'b0; bus.penable = 1'b0;
    #1 check("clrnew_fv",    64'(fault_valid), 64'(1));
    check("clrnew_faddr",  64'(fault_addr),  64'(32'h4000_0000));
    check("clrnew_fcause", 64'(fault_cause), 64'(0));
    tick();

    // Reset in the third ACCESS cycle of an SRAM read.
    bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = 32'h8000_0020;
    tick();
    bus.penable = 1'b1;
    tick();
    tick();
    bus.s_pready = 3'b100; bus.s_prdata[64 +: 32] = 32'h5555_AAAA;
    presetn = 1'b0;
    #1 check("rstmid_s_psel", 64'(bus.s_psel),    64'(0));
    check("rstmid_s_pen",  64'(bus.s_penable), 64'(0));
    check("rstmid_pready", 64'(bus.pready),    64'(0));
    check("rstmid_perr",   64'(bus.perr),      64'(0));
    check("rstmid_prdata", 64'(bus.prdata),    64'(0));
    check("rstmid_fv",     64'(fault_valid),   64'(0));
    tick();
    bus.psel = 1'b0; bus.penable = 1'b0; bus.s_pready = '0;
    tick();
    presetn = 1'b1;
    tick();
    bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = 32'h8000_0010;
    tick();
    bus.penable = 1'b1; bus.s_pready = 3'b100; bus.s_prdata[64 +: 32] = 32'hCAFE_F00D;
    #1 check("postrst_pready", 64'(bus.pready), 64'(1));
    check("postrst_prdata", 64'(bus.prdata), 64'(32'hCAFE_F00D));
    tick();
    bus.psel = 1'b0; bus.penable = 1'b0; bus.s_pready = '0;
    tick();

    // Back-to-back system reads, psel held high; second returns a slave error.
    bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = 32'h0000_0000;
    tick();
    bus.penable = 1'b1; bus.s_pready = 3'b001; bus.s_prdata[0 +: 32] = 32'h1111_1111;
    #1 check("b2b1_pready", 64'(bus.pready), 64'(1));
    check("b2b1_prdata", 64'(bus.prdata), 64'(32'h1111_1111));
    tick();
    bus.paddr = 32'h0000_0004; bus.penable = 1'b0; bus.s_pready = '0;
    #1 check("b2b2_setup_psel", 64'(bus.s_psel), 64'(3'b001));
    check("b2b2_setup_pready", 64'(bus.pready), 64'(0));
    tick();
    bus.penable = 1'b1; bus.s_pready = 3'b001; bus.s_perr = 3'b001;
    bus.s_prdata[0 +: 32] = 32'h2222_2222;
    #1 check("b2b2_pready", 64'(bus.pready), 64'(1));
    check("b2b2_prdata", 64'(bus.prdata), 64'(32'h2222_2222));
    check("b2b2_perr",   64'(bus.perr),   64'(1));
    tick();
    bus.psel = 1'b0; bus.penable = 1'b0; bus.s_pready = '0; bus.s_perr = '0;
    #1 check("slverr_not_captured", 64'(fault_valid), 64'(0));
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
